// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, data, optional parity and
// one or two stop bits around a shared serializer and drives the serial line.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  busy,
  output logic                  TX_OUT,
  output logic                  frame_done,
  output logic                  ser_err
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_t;

  state_t          state_q, next_state;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            par_bit_q, par_en_q, stop2_q;
  logic            ser_err_q;
  logic            accept, last_data, done_viol;

  assign accept    = (state_q == S_IDLE) && Data_Valid && !busy_q;
  assign last_data = (state_q == S_DATA) && (cnt_q == CW'(DATA_WIDTH - 1));

  // ser_done must stay low while shifting and be high in the first cycle after DATA.
  assign done_viol = ((state_q == S_DATA) && ser_done) ||
                     (((state_q == S_PARITY) || ((state_q == S_STOP1) && !par_en_q)) && !ser_done);

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) next_state = S_START;
      S_START:  next_state = S_DATA;
      S_DATA:   if (last_data) next_state = par_en_q ? S_PARITY : S_STOP1;
      S_PARITY: next_state = S_STOP1;
      S_STOP1:  next_state = stop2_q ? S_STOP2 : S_IDLE;
      S_STOP2:  next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      ser_err_q <= 1'b0;
    end else begin
      state_q <= next_state;
      busy_q  <= (next_state != S_IDLE);
      cnt_q   <= (state_q == S_DATA) ? cnt_q + 1'b1 : '0;
      if (accept) begin
        par_bit_q <= (^P_DATA) ^ PAR_TYP;
        par_en_q  <= PAR_EN;
        stop2_q   <= STOP2;
        ser_err_q <= 1'b0;
      end else if (done_viol) begin
        ser_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    TX_OUT = 1'b1;
    unique case (state_q)
      S_IDLE:   TX_OUT = 1'b1;
      S_START:  TX_OUT = 1'b0;
      S_DATA:   TX_OUT = ser_data;
      S_PARITY: TX_OUT = par_bit_q;
      S_STOP1:  TX_OUT = 1'b1;
      S_STOP2:  TX_OUT = 1'b1;
      default:  TX_OUT = 1'b1;
    endcase
  end

  assign ser_en     = (state_q == S_DATA);
  assign busy       = busy_q;
  assign frame_done = ((state_q == S_STOP1) && !stop2_q) || (state_q == S_STOP2);
  assign ser_err    = ser_err_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a stub serializer feeds the controller and a
// scoreboard of per-cycle line/pulse expectations is checked against the DUT.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid, PAR_EN, PAR_TYP, STOP2;
  logic       ser_data, ser_done;
  logic       ser_en, busy, TX_OUT, frame_done, ser_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic tx;
    logic fd;
    logic se;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .ser_en     (ser_en),
    .busy       (busy),
    .TX_OUT     (TX_OUT),
    .frame_done (frame_done),
    .ser_err    (ser_err)
  );

  // Stub serializer: loads while idle, shifts LSB-first on ser_en.
  logic [7:0] sreg;
  logic [3:0] scnt;
  logic       done_d;
  bit         late = 1'b0;

  always @(posedge CLK) begin
    if (!busy) begin
      sreg <= P_DATA;
      scnt <= 4'd0;
    end else if (ser_en) begin
      sreg <= sreg >> 1;
      scnt <= scnt + 4'd1;
    end
    done_d <= (scnt == 4'd8);
  end

  assign ser_data = sreg[0];
  assign ser_done = late ? done_d : (scnt == 4'd8);

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; pushes the expected frame, requests it
  // and pops/compares one entry per busy cycle.
  task automatic do_frame(input logic [7:0] d, input logic pe, input logic pt,
                          input logic s2, input bit hold, input int disturb,
                          input logic exp_err);
    exp_t e;
    int   idx;
    sb.push_back('{tx: 1'b0, fd: 1'b0, se: 1'b0});
    for (int i = 0; i < 8; i++) sb.push_back('{tx: d[i], fd: 1'b0, se: 1'b1});
    if (pe) sb.push_back('{tx: (^d) ^ pt, fd: 1'b0, se: 1'b0});
    sb.push_back('{tx: 1'b1, fd: !s2, se: 1'b0});
    if (s2) sb.push_back('{tx: 1'b1, fd: 1'b1, se: 1'b0});

    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; Data_Valid = 1'b1;
    @(negedge CLK);
    if (!hold) Data_Valid = 1'b0;
    idx = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("busy[%0d]", idx), busy, 1'b1);
      check($sformatf("tx[%0d]", idx), TX_OUT, e.tx);
      check($sformatf("frame_done[%0d]", idx), frame_done, e.fd);
      check($sformatf("ser_en[%0d]", idx), ser_en, e.se);
      if (idx == 0) check("ser_err_clear_at_accept", ser_err, 1'b0);
      if (idx == disturb) begin
        Data_Valid = 1'b1; P_DATA = 8'h11; PAR_EN = !PAR_EN;
      end
      if (idx == disturb + 1) Data_Valid = 1'b0;
      idx++;
      @(negedge CLK);
    end
    check("busy_end", busy, 1'b0);
    check("tx_idle_end", TX_OUT, 1'b1);
    check("ser_en_end", ser_en, 1'b0);
    check("ser_err_end", ser_err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; P_DATA = 8'h00; Data_Valid = 1'b0;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy", busy, 1'b0);
    check("rst_tx", TX_OUT, 1'b1);
    check("rst_ser_en", ser_en, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_ser_err", ser_err, 1'b0);
    RST = 1'b0;
    @(negedge CLK);

    do_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -10, 1'b0);
    do_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, -10, 1'b0);
    do_frame(8'h03, 1'b1, 1'b1, 1'b0, 1'b0, -10, 1'b0);
    do_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, -10, 1'b0);

    // Request and parity enable disturbed during DATA.
    do_frame(8'h6C, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    do_frame(8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0);

    // Data_Valid held high: frames separated by exactly one idle cycle.
    do_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b1, -10, 1'b0);
    do_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b1, -10, 1'b0);
    do_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b0, -10, 1'b0);

    // Asynchronous reset during the 4th DATA cycle.
    P_DATA = 8'hA5; PAR_EN = 1'b0; STOP2 = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("pre_rst_ser_en", ser_en, 1'b1);
    check("pre_rst_busy", busy, 1'b1);
    RST = 1'b1;
    #1;
    check("async_rst_tx", TX_OUT, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_ser_en", ser_en, 1'b0);
    check("async_rst_frame_done", frame_done, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_idle_busy", busy, 1'b0);
    check("post_rst_idle_tx", TX_OUT, 1'b1);
    do_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -10, 1'b0);

    // Late ser_done: sticky error through idle, cleared by the next accept.
    late = 1'b1;
    do_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("ser_err_sticky[%0d]", i), ser_err, 1'b1);
      check($sformatf("idle_busy[%0d]", i), busy, 1'b0);
    end
    late = 1'b0;
    do_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, -10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame controller for the UART transmit path.
- Accepts a parallel byte on Data_Valid and latches the frame configuration.
- Sequences the shared serializer through start, data, optional parity and 1 or 2 stop bits.
- Drives the serial line TX_OUT.
- Sits between the system-side TX FIFO/read logic and the serializer; owns busy, ser_en and the line mux.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must match the serializer's DATA_LENGTH.

Ports:
- CLK  in  1  transmit clock; one bit period per cycle.
- RST  in  1  asynchronous, active-high reset.
- P_DATA  in  DATA_WIDTH  byte to send; used only for parity computation (the serializer loads the same bus).
- Data_Valid  in  1  request; accepted only when busy=0.
- PAR_EN  in  1  1 = insert parity bit.
- PAR_TYP  in  1  0 = even, 1 = odd.
- STOP2  in  1  1 = two stop bits.
- ser_data  in  1  current serializer LSB.
- ser_done  in  1  serializer has shifted DATA_WIDTH bits.
- ser_en  out  1  serializer shift enable.
- busy  out  1  frame in progress; also blocks the serializer load.
- TX_OUT  out  1  serial line.
- frame_done  out  1  one-cycle pulse on the final stop-bit cycle.
- ser_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (RST=1, async):
  - State goes to IDLE; bit counter and latched configuration are cleared.
  - ser_en=0, busy=0, frame_done=0, ser_err=0, TX_OUT=1.
  - Applies immediately mid-frame; no partial frame is resumed after release.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- busy is registered, equal to (state != IDLE).
- TX_OUT is a combinational select of registered sources:
  - IDLE = 1
  - START = 0
  - DATA = ser_data
  - PARITY = latched parity bit
  - STOP1/STOP2 = 1
- Accept: in IDLE, when Data_Valid=1 and busy=0:
  - Next state is START.
  - Latch par_bit = (XOR-reduce of P_DATA) XOR PAR_TYP.
  - Latch PAR_EN and STOP2.
  - Configuration changes after accept have no effect on the current frame.
- START: lasts 1 cycle, then DATA. ser_en=0 in START.
- DATA:
  - ser_en=1 for exactly DATA_WIDTH cycles, counted by an internal $clog2(DATA_WIDTH)+1-bit counter.
  - On the last DATA cycle, the next state is PARITY if PAR_EN is latched, else STOP1.
- PARITY: 1 cycle, then STOP1.
- STOP1: 1 cycle; next state is STOP2 if STOP2 is latched, else IDLE.
- STOP2: 1 cycle, then IDLE.
- frame_done = 1 combinationally during the final stop cycle (STOP1 with STOP2 unlatched, or STOP2).
- Frame length in busy cycles = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2.
- Minimum gap between frames: one IDLE cycle. busy is high during the final stop cycle, so back-to-back Data_Valid is accepted in the following IDLE cycle.
- ser_done check:
  - ser_done must be 0 throughout DATA and 1 in the first cycle after DATA.
  - Any violation sets ser_err; it holds until the next accept, where it clears.
  - An error does not alter sequencing.
- Data_Valid while busy=1 is ignored; no queueing and no state change.
- Data_Valid held high across a frame end starts a new frame on the first IDLE cycle.

Test Plan:
- Reset, then Data_Valid pulse with P_DATA=8'hA5, PAR_EN=0, STOP2=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop); busy high exactly 10 cycles; frame_done pulses on cycle 10; ser_err=0.
- P_DATA=8'h03, PAR_EN=1, PAR_TYP=0 -> parity bit 0, 11 busy cycles. Repeat with PAR_TYP=1 -> parity bit 1.
- P_DATA=8'hFF, PAR_EN=1, PAR_TYP=1, STOP2=1 -> parity bit 1, two stop bits, 12 busy cycles; frame_done only on the second stop cycle.
- Data_Valid re-pulsed with 8'h11 during DATA, and PAR_EN toggled mid-frame -> current frame unchanged, 8'h11 not sent. Data_Valid held high continuously -> frames separated by exactly one IDLE cycle (TX_OUT=1).
- RST asserted during the 4th DATA cycle -> TX_OUT=1, busy=0, ser_en=0 immediately, without waiting for a clock edge. After release, a new 8'h5A frame is sent correctly.
- Stub serializer drives ser_done one cycle late -> ser_err=1 and stays 1 through IDLE; next accepted frame with a correct stub -> ser_err clears at accept.
